// File: rtl/ifu_axi_pkg.sv
// Shared types and constants for the instruction fetch unit and its AXI4-Lite read port.
package ifu_axi_pkg;

  localparam int          IFU_XLEN_DEF   = 32;
  localparam logic [31:0] FAULT_INST_DEF = 32'h00100073; // EBREAK: a faulted fetch halts the core

  typedef enum logic [1:0] {
    IFU_IDLE,
    IFU_ADDR,
    IFU_DATA,
    IFU_RESP
  } ifu_state_e;

  typedef enum logic [1:0] {
    AXI_OKAY   = 2'b00,
    AXI_EXOKAY = 2'b01,
    AXI_SLVERR = 2'b10,
    AXI_DECERR = 2'b11
  } axi_resp_e;

  function automatic logic word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/ifu_axi_if.sv
// Core-side fetch handshake plus AXI4-Lite read channels of the fetch unit.
// master = the fetch unit; slave = the core FSM and instruction bus around it.
interface ifu_axi_if #(
  parameter int XLEN = 32
) ();

  logic            ifu_reqValid;
  logic [XLEN-1:0] pc;
  logic            ifu_respValid;
  logic [XLEN-1:0] inst;
  logic            fault;

  logic [XLEN-1:0] araddr;
  logic            arvalid;
  logic            arready;
  logic [XLEN-1:0] rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;

  modport master (
    input  ifu_reqValid, pc, arready, rdata, rresp, rvalid,
    output ifu_respValid, inst, fault, araddr, arvalid, rready
  );

  modport slave (
    output ifu_reqValid, pc, arready, rdata, rresp, rvalid,
    input  ifu_respValid, inst, fault, araddr, arvalid, rready
  );

endinterface

// File: rtl/ifu_perf.sv
// Fetch and bus-stall counters; only built when IFU_PERF_EN is defined.
`ifdef IFU_PERF_EN
module ifu_perf
  import ifu_axi_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  ifu_state_e  state_i,
  output logic [31:0] perf_fetches_o,
  output logic [31:0] perf_stall_cycles_o
);

  logic [31:0] fetches_q, stalls_q;

  // Both counters wrap silently; consumers take differences.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetches_q <= '0;
      stalls_q  <= '0;
    end else begin
      if (state_i == IFU_RESP)
        fetches_q <= fetches_q + 32'd1;
      if (state_i == IFU_ADDR || state_i == IFU_DATA)
        stalls_q <= stalls_q + 32'd1;
    end
  end

  assign perf_fetches_o      = fetches_q;
  assign perf_stall_cycles_o = stalls_q;

endmodule
`endif

// File: rtl/ifu_axi.sv
// Instruction fetch unit: one AXI4-Lite read per fetch request, single-cycle response pulse.
// Optional IFU_PERF_EN adds perf_fetches / perf_stall_cycles counters.
module ifu_axi
  import ifu_axi_pkg::*;
#(
  parameter int              XLEN       = IFU_XLEN_DEF,
  parameter logic [XLEN-1:0] FAULT_INST = XLEN'(FAULT_INST_DEF)
) (
  input logic        clock,
  input logic        reset,
  ifu_axi_if.master  bus
`ifdef IFU_PERF_EN
  ,
  output logic [31:0] perf_fetches,
  output logic [31:0] perf_stall_cycles
`endif
);

  ifu_state_e      state_q;
  logic [XLEN-1:0] araddr_q;
  logic            arvalid_q;
  logic            rready_q;
  logic            resp_q;
  logic [XLEN-1:0] inst_q;
  logic            fault_q;

  // pc is only sampled in IDLE, so araddr stays put for the whole transaction.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IFU_IDLE;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      resp_q    <= 1'b0;
      inst_q    <= FAULT_INST;
      fault_q   <= 1'b0;
    end else begin
      resp_q <= 1'b0;
      case (state_q)
        IFU_IDLE: begin
          if (bus.ifu_reqValid) begin
            araddr_q <= bus.pc;
            if (word_aligned(bus.pc[1:0])) begin
              arvalid_q <= 1'b1;
              state_q   <= IFU_ADDR;
            end else begin
              inst_q  <= FAULT_INST;
              fault_q <= 1'b1;
              resp_q  <= 1'b1;
              state_q <= IFU_RESP;
            end
          end
        end
        IFU_ADDR: begin
          if (bus.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= IFU_DATA;
          end
        end
        IFU_DATA: begin
          if (bus.rvalid) begin
            rready_q <= 1'b0;
            resp_q   <= 1'b1;
            state_q  <= IFU_RESP;
            if (bus.rresp == AXI_OKAY) begin
              inst_q  <= bus.rdata;
              fault_q <= 1'b0;
            end else begin
              inst_q  <= FAULT_INST;
              fault_q <= 1'b1;
            end
          end
        end
        IFU_RESP: state_q <= IFU_IDLE;
        default:  state_q <= IFU_IDLE;
      endcase
    end
  end

  assign bus.araddr        = araddr_q;
  assign bus.arvalid       = arvalid_q;
  assign bus.rready        = rready_q;
  assign bus.ifu_respValid = resp_q;
  assign bus.inst          = inst_q;
  assign bus.fault         = fault_q;

`ifdef IFU_PERF_EN
  ifu_perf u_perf (
    .clock              (clock),
    .reset              (reset),
    .state_i            (state_q),
    .perf_fetches_o     (perf_fetches),
    .perf_stall_cycles_o(perf_stall_cycles)
  );
`endif

endmodule

// File: tb/tb_ifu_axi.sv
// Self-checking bench for ifu_axi: AXI slave model with programmable waits, response scoreboard.
module tb_ifu_axi;
  import ifu_axi_pkg::*;

  localparam int          XLEN = 32;
  localparam logic [31:0] FI   = 32'h00100073;

  logic clock = 1'b0;
  logic reset = 1'b1;

  ifu_axi_if #(.XLEN(XLEN)) bus ();

`ifdef IFU_PERF_EN
  logic [31:0] perf_fetches, perf_stall_cycles;
`endif

  ifu_axi #(.XLEN(XLEN)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
`ifdef IFU_PERF_EN
    ,
    .perf_fetches     (perf_fetches),
    .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] inst;
    logic        fault;
  } rsp_t;

  rsp_t        exp_q[$];
  rsp_t        obs_q[$];
  int unsigned obs_cyc_q[$];

  int          ar_count   = 0;
  int          resp_count = 0;
  int          stab_err   = 0;
  logic [31:0] last_araddr = '0;

  // Slave configuration, set by the fetch task before each request.
  int          ar_delay  = 0;
  int          r_delay   = 0;
  logic [31:0] cfg_rdata = '0;
  logic [1:0]  cfg_rresp = 2'b00;

  // AXI read slave: drives at negedge, shares the DUT reset.
  initial begin
    int phase;
    int cnt;
    phase = 0;
    cnt   = 0;
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    bus.rdata   = '0;
    bus.rresp   = 2'b00;
    forever begin
      @(negedge clock);
      if (reset) begin
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        phase = 0;
        cnt   = 0;
      end else begin
        case (phase)
          0: if (bus.arvalid) begin
               if (cnt >= ar_delay) begin
                 bus.arready = 1'b1;
                 phase = 1;
                 cnt   = 0;
               end else cnt++;
             end
          1: begin
               bus.arready = 1'b0;
               if (r_delay == 0) begin
                 bus.rvalid = 1'b1; bus.rdata = cfg_rdata; bus.rresp = cfg_rresp;
                 phase = 3;
               end else begin
                 cnt   = 1;
                 phase = 2;
               end
             end
          2: if (cnt >= r_delay) begin
               bus.rvalid = 1'b1; bus.rdata = cfg_rdata; bus.rresp = cfg_rresp;
               phase = 3;
             end else cnt++;
          default: begin
               bus.rvalid = 1'b0;
               bus.rdata  = '0;
               phase = 0;
               cnt   = 0;
             end
        endcase
      end
    end
  end

  // Monitor: counts read requests and response pulses, flags unstable address/inst.
  initial begin
    logic        prev_arvalid;
    logic [31:0] prev_araddr, prev_inst;
    logic        prev_fault;
    prev_arvalid = 1'b0;
    prev_araddr  = '0;
    prev_inst    = FI;
    prev_fault   = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_arvalid = 1'b0;
        prev_inst    = bus.inst;
        prev_fault   = bus.fault;
      end else begin
        if (bus.arvalid && !prev_arvalid) begin
          ar_count++;
          last_araddr = bus.araddr;
        end
        if (bus.arvalid && prev_arvalid && bus.araddr !== prev_araddr) stab_err++;
        if (!bus.ifu_respValid && (bus.inst !== prev_inst || bus.fault !== prev_fault)) stab_err++;
        if (bus.ifu_respValid) begin
          resp_count++;
          obs_q.push_back('{bus.inst, bus.fault});
          obs_cyc_q.push_back(cyc);
        end
        prev_arvalid = bus.arvalid;
        prev_araddr  = bus.araddr;
        prev_inst    = bus.inst;
        prev_fault   = bus.fault;
      end
    end
  end

  // One complete fetch; the request is held high until the response pulse is seen.
  task automatic fetch(input logic [31:0] addr, input int ard, input int rd,
                       input logic [31:0] data, input logic [1:0] rsp,
                       input bit at_once, input string name);
    rsp_t        e;
    rsp_t        o;
    int unsigned acc, oc, exp_lat;
    int          ar0, r0;
    bit          mis, got;
    mis       = (addr[1:0] != 2'b00);
    ar_delay  = ard;
    r_delay   = rd;
    cfg_rdata = data;
    cfg_rresp = rsp;
    e.inst    = (mis || rsp != 2'b00) ? FI : data;
    e.fault   = mis || (rsp != 2'b00);
    exp_q.push_back(e);
    exp_lat   = mis ? 1 : 3 + ard + rd;
    ar0 = ar_count;
    r0  = resp_count;
    if (!at_once) @(negedge clock);
    bus.ifu_reqValid = 1'b1;
    bus.pc           = addr;
    acc = cyc;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clock);
      #1;
      bus.pc = addr ^ 32'h0000_1000;
      if (obs_q.size() > 0) got = 1'b1;
    end
    bus.ifu_reqValid = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s timeout: no respValid within 60 cycles", name);
      void'(exp_q.pop_front());
    end else begin
      o  = obs_q.pop_front();
      oc = obs_cyc_q.pop_front();
      e  = exp_q.pop_front();
      checks++;
      if (o.inst !== e.inst) begin
        errors++; $display("FAIL %s inst got=%h exp=%h", name, o.inst, e.inst);
      end
      checks++;
      if (o.fault !== e.fault) begin
        errors++; $display("FAIL %s fault got=%b exp=%b", name, o.fault, e.fault);
      end
      checks++;
      if (oc - acc !== exp_lat) begin
        errors++; $display("FAIL %s latency got=%0d exp=%0d", name, oc - acc, exp_lat);
      end
    end
    checks++;
    if (ar_count - ar0 !== (mis ? 0 : 1)) begin
      errors++; $display("FAIL %s read count got=%0d exp=%0d", name, ar_count - ar0, mis ? 0 : 1);
    end
    if (!mis) begin
      checks++;
      if (last_araddr !== addr) begin
        errors++; $display("FAIL %s bus araddr got=%h exp=%h", name, last_araddr, addr);
      end
    end
    checks++;
    if (bus.araddr !== addr) begin
      errors++; $display("FAIL %s latched araddr got=%h exp=%h", name, bus.araddr, addr);
    end
    for (int i = 0; i < 3; i++) @(negedge clock);
    checks++;
    if (resp_count - r0 !== 1 || obs_q.size() != 0) begin
      errors++; $display("FAIL %s pulse count got=%0d exp=1", name, resp_count - r0);
    end
  endtask

  task automatic test_reset();
    bus.ifu_reqValid = 1'b0;
    bus.pc           = '0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if ({bus.arvalid, bus.rready, bus.ifu_respValid, bus.fault} !== 4'b0000) begin
      errors++;
      $display("FAIL reset ctrl got=%b exp=0000", {bus.arvalid, bus.rready, bus.ifu_respValid, bus.fault});
    end
    checks++;
    if (bus.inst !== FI || bus.araddr !== 32'h0) begin
      errors++; $display("FAIL reset data inst=%h araddr=%h exp inst=%h araddr=0", bus.inst, bus.araddr, FI);
    end
    reset = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_zero_wait();
    fetch(32'h8000_0000, 0, 0, 32'h0050_0093, AXI_OKAY, 1'b0, "zero_wait");
    fetch(32'h8000_0004, 0, 0, 32'hA5A5_5A5A, AXI_OKAY, 1'b0, "zero_wait2");
  endtask

  task automatic test_wait_states();
    int s0;
    s0 = stab_err;
    fetch(32'h8000_0010, 4, 3, 32'h1234_5678, AXI_OKAY, 1'b0, "wait_states");
    fetch(32'h8000_0020, 0, 5, 32'h0FF0_0FF0, AXI_OKAY, 1'b0, "wait_rdata");
    checks++;
    if (stab_err !== s0) begin
      errors++; $display("FAIL wait_stability events got=%0d exp=0", stab_err - s0);
    end
  endtask

  task automatic test_misaligned();
    fetch(32'h8000_0002, 0, 0, 32'h1111_1111, AXI_OKAY, 1'b0, "misaligned2");
    fetch(32'h8000_0001, 0, 0, 32'h2222_2222, AXI_OKAY, 1'b0, "misaligned1");
  endtask

  task automatic test_bus_error();
    fetch(32'h8000_0100, 1, 0, 32'hDEAD_BEEF, AXI_SLVERR, 1'b0, "slverr");
    fetch(32'h8000_0104, 0, 2, 32'hCAFE_F00D, AXI_DECERR, 1'b0, "decerr");
    fetch(32'h8000_0108, 0, 0, 32'h0000_0013, AXI_OKAY, 1'b0, "err_clear");
  endtask

  task automatic test_reset_mid();
    ar_delay = 0;
    r_delay  = 20;
    @(negedge clock);
    bus.ifu_reqValid = 1'b1;
    bus.pc           = 32'h8000_0040;
    repeat (2) @(negedge clock);
    checks++;
    if (bus.rready !== 1'b1) begin
      errors++; $display("FAIL reset_mid in_data rready got=%b exp=1", bus.rready);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({bus.arvalid, bus.rready, bus.ifu_respValid} !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid async got=%b exp=000", {bus.arvalid, bus.rready, bus.ifu_respValid});
    end
    bus.pc = 32'h8000_0080;
    repeat (2) @(negedge clock);
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL reset_mid stray responses got=%0d exp=0", obs_q.size());
    end
    reset = 1'b0;
    fetch(32'h8000_0080, 0, 0, 32'h0010_0513, AXI_OKAY, 1'b1, "after_reset");
  endtask

`ifdef IFU_PERF_EN
  task automatic test_perf();
    logic [31:0] f0, s0;
    f0 = perf_fetches;
    s0 = perf_stall_cycles;
    fetch(32'h8000_0200, 1, 1, 32'h0000_0001, AXI_OKAY, 1'b0, "perf1");
    fetch(32'h8000_0204, 1, 1, 32'h0000_0002, AXI_OKAY, 1'b0, "perf2");
    fetch(32'h8000_0208, 1, 1, 32'h0000_0003, AXI_SLVERR, 1'b0, "perf3");
    checks++;
    if (perf_fetches - f0 !== 32'd3) begin
      errors++; $display("FAIL perf_fetches delta got=%0d exp=3", perf_fetches - f0);
    end
    checks++;
    if (perf_stall_cycles - s0 !== 32'd12) begin
      errors++; $display("FAIL perf_stall_cycles delta got=%0d exp=12", perf_stall_cycles - s0);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_misaligned();
    test_bus_error();
    test_reset_mid();
`ifdef IFU_PERF_EN
    test_perf();
`endif
    checks++;
    if (stab_err !== 0) begin
      errors++; $display("FAIL overall stability events got=%0d exp=0", stab_err);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
